// File: rtl/logic_reduce_accum_if.sv
// Stream bundle for logic_reduce_accum: operand beats in, folded summary out.
interface logic_reduce_accum_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_bit;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  // Stream source / result consumer side.
  modport master (
    output in_data, in_op, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_bit, out_count, out_sat, out_valid
  );

  // Reducer side.
  modport slave (
    input  in_data, in_op, in_last, in_valid, out_ready,
    output in_ready, out_data, out_bit, out_count, out_sat, out_valid
  );
endinterface

// File: rtl/logic_reduce_accum.sv
// Per-packet bitwise fold (AND/OR/XOR/NAND) with beat count and a registered
// result held until the consumer takes it.
module logic_reduce_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  logic_reduce_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0]       OP_AND  = 2'd0;
  localparam logic [1:0]       OP_OR   = 2'd1;
  localparam logic [1:0]       OP_XOR  = 2'd2;
  localparam logic [1:0]       OP_NAND = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             accept;

  // in_ready depends only on the state register, so no out_ready->in_ready path.
  assign accept = bus.in_valid && (state_q != HOLD);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: open on first beat, close on in_last, release on out_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d = bus.in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: first beat loads directly, later beats fold.
  // NAND folds as AND; the inversion happens only at the output.
  always_comb begin
    acc_d = acc_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (accept) begin
      if (state_q == IDLE) begin
        acc_d = bus.in_data;
        op_d  = bus.in_op;
        cnt_d = CNT_ONE;
        sat_d = 1'b0;
      end else begin
        case (op_q)
          OP_OR:   acc_d = acc_q | bus.in_data;
          OP_XOR:  acc_d = acc_q ^ bus.in_data;
          default: acc_d = acc_q & bus.in_data;
        endcase
        if (cnt_q == CNT_MAX) begin
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      op_q  <= OP_AND;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    bus.in_ready  = (state_q != HOLD);
    bus.out_valid = (state_q == HOLD);
    bus.out_count = cnt_q;
    bus.out_sat   = sat_q;
    bus.out_data  = acc_q;
    bus.out_bit   = &acc_q;
    case (op_q)
      OP_AND: begin
        bus.out_data = acc_q;
        bus.out_bit  = &acc_q;
      end
      OP_OR: begin
        bus.out_data = acc_q;
        bus.out_bit  = |acc_q;
      end
      OP_XOR: begin
        bus.out_data = acc_q;
        bus.out_bit  = ^acc_q;
      end
      OP_NAND: begin
        bus.out_data = ~acc_q;
        bus.out_bit  = ~(&acc_q);
      end
      default: begin
        bus.out_data = acc_q;
        bus.out_bit  = &acc_q;
      end
    endcase
  end

endmodule

// File: tb/tb_logic_reduce_accum.sv
// Directed bench for logic_reduce_accum: an 8/8 instance for the main
// features and an 8/2 instance for counter saturation.
module tb_logic_reduce_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  logic_reduce_accum_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
  logic_reduce_accum_if #(.WIDTH(8), .CNT_W(2)) buss ();

  logic_reduce_accum #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clock (clk),
    .reset (rst),
    .bus   (bus8)
  );

  logic_reduce_accum #(.WIDTH(8), .CNT_W(2)) duts (
    .clock (clk),
    .reset (rst),
    .bus   (buss)
  );

  // One accept cycle on the 8/8 instance (or an idle cycle when valid=0).
  task automatic drive8(input logic [7:0] d, input logic [1:0] op,
                        input logic last, input logic valid);
    bus8.in_data  = d;
    bus8.in_op    = op;
    bus8.in_last  = last;
    bus8.in_valid = valid;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic drives(input logic [7:0] d, input logic [1:0] op,
                        input logic last);
    buss.in_data  = d;
    buss.in_op    = op;
    buss.in_last  = last;
    buss.in_valid = 1'b1;
    @(posedge clk); #1;
    buss.in_valid = 1'b0;
  endtask

  task automatic pop8();
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus8.in_ready); else n_pass++;
    n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus8.out_valid); else n_pass++;
    n_checks++; if (bus8.out_data !== 8'h00) $display("FAIL reset_out_data got=%h want=00", bus8.out_data); else n_pass++;
    n_checks++; if (bus8.out_bit !== 1'b0) $display("FAIL reset_out_bit got=%b want=0", bus8.out_bit); else n_pass++;
    n_checks++; if (bus8.out_count !== 8'd0) $display("FAIL reset_out_count got=%0d want=0", bus8.out_count); else n_pass++;
    n_checks++; if (bus8.out_sat !== 1'b0) $display("FAIL reset_out_sat got=%b want=0", bus8.out_sat); else n_pass++;
    n_checks++; if (buss.out_count !== 2'd0) $display("FAIL reset_small_count got=%0d want=0", buss.out_count); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_packet();
    drive8(8'hAA, 2'd1, 1'b0, 1'b1);
    drive8(8'h55, 2'd1, 1'b0, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b want=0", bus8.out_valid); else n_pass++;
    n_checks++; if (bus8.out_data !== 8'h00) $display("FAIL midrst_out_data got=%h want=00", bus8.out_data); else n_pass++;
    n_checks++; if (bus8.out_count !== 8'd0) $display("FAIL midrst_out_count got=%0d want=0", bus8.out_count); else n_pass++;
    n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%b want=1", bus8.in_ready); else n_pass++;
    // Fresh single-beat packet after reset: OR of one word is the word itself.
    drive8(8'h0F, 2'd1, 1'b1, 1'b1);
    n_checks++; if (bus8.out_valid !== 1'b1) $display("FAIL fresh_out_valid got=%b want=1", bus8.out_valid); else n_pass++;
    n_checks++; if (bus8.out_data !== 8'h0F) $display("FAIL fresh_out_data got=%h want=0f", bus8.out_data); else n_pass++;
    n_checks++; if (bus8.out_count !== 8'd1) $display("FAIL fresh_out_count got=%0d want=1", bus8.out_count); else n_pass++;
    pop8();
    $display("test_reset_mid_packet done");
  endtask

  task automatic test_and();
    drive8(8'hF3, 2'd0, 1'b0, 1'b1);
    drive8(8'h3F, 2'd0, 1'b0, 1'b1);
    n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL and_early_valid got=%b want=0", bus8.out_valid); else n_pass++;
    drive8(8'hB7, 2'd0, 1'b1, 1'b1);
    n_checks++; if (bus8.out_valid !== 1'b1) $display("FAIL and_out_valid got=%b want=1", bus8.out_valid); else n_pass++;
    n_checks++; if (bus8.out_data !== 8'h33) $display("FAIL and_out_data got=%h want=33", bus8.out_data); else n_pass++;
    n_checks++; if (bus8.out_bit !== 1'b0) $display("FAIL and_out_bit got=%b want=0", bus8.out_bit); else n_pass++;
    n_checks++; if (bus8.out_count !== 8'd3) $display("FAIL and_out_count got=%0d want=3", bus8.out_count); else n_pass++;
    n_checks++; if (bus8.out_sat !== 1'b0) $display("FAIL and_out_sat got=%b want=0", bus8.out_sat); else n_pass++;
    pop8();
    n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL and_after_pop_valid got=%b want=0", bus8.out_valid); else n_pass++;
    $display("test_and done");
  endtask

  task automatic test_xor_gaps();
    drive8(8'h01, 2'd2, 1'b0, 1'b1);
    drive8(8'hFF, 2'd1, 1'b1, 1'b0);
    drive8(8'hFF, 2'd1, 1'b1, 1'b0);
    n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL xor_gap_in_ready got=%b want=1", bus8.in_ready); else n_pass++;
    n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL xor_gap_out_valid got=%b want=0", bus8.out_valid); else n_pass++;
    drive8(8'h03, 2'd1, 1'b0, 1'b1);
    drive8(8'h80, 2'd1, 1'b1, 1'b1);
    n_checks++; if (bus8.out_valid !== 1'b1) $display("FAIL xor_out_valid got=%b want=1", bus8.out_valid); else n_pass++;
    n_checks++; if (bus8.out_data !== 8'h82) $display("FAIL xor_out_data got=%h want=82", bus8.out_data); else n_pass++;
    n_checks++; if (bus8.out_bit !== 1'b0) $display("FAIL xor_out_bit got=%b want=0", bus8.out_bit); else n_pass++;
    n_checks++; if (bus8.out_count !== 8'd3) $display("FAIL xor_out_count got=%0d want=3", bus8.out_count); else n_pass++;
    pop8();
    $display("test_xor_gaps done");
  endtask

  task automatic test_nand();
    drive8(8'hFF, 2'd3, 1'b1, 1'b1);
    n_checks++; if (bus8.out_data !== 8'h00) $display("FAIL nand_ff_data got=%h want=00", bus8.out_data); else n_pass++;
    n_checks++; if (bus8.out_bit !== 1'b0) $display("FAIL nand_ff_bit got=%b want=0", bus8.out_bit); else n_pass++;
    n_checks++; if (bus8.out_count !== 8'd1) $display("FAIL nand_ff_count got=%0d want=1", bus8.out_count); else n_pass++;
    pop8();
    drive8(8'h7F, 2'd3, 1'b1, 1'b1);
    n_checks++; if (bus8.out_data !== 8'h80) $display("FAIL nand_7f_data got=%h want=80", bus8.out_data); else n_pass++;
    n_checks++; if (bus8.out_bit !== 1'b1) $display("FAIL nand_7f_bit got=%b want=1", bus8.out_bit); else n_pass++;
    pop8();
    $display("test_nand done");
  endtask

  task automatic test_back_to_back();
    drive8(8'h5A, 2'd1, 1'b1, 1'b1);
    // Offer a new beat while the result is held back.
    bus8.in_data  = 8'h11;
    bus8.in_op    = 2'd1;
    bus8.in_last  = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bus8.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, bus8.in_ready); else n_pass++;
      n_checks++; if (bus8.out_valid !== 1'b1 || bus8.out_data !== 8'h5A || bus8.out_count !== 8'd1)
        $display("FAIL bp_hold cyc=%0d got valid=%b data=%h cnt=%0d want valid=1 data=5a cnt=1",
                 i, bus8.out_valid, bus8.out_data, bus8.out_count);
      else n_pass++;
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b want=0", bus8.out_valid); else n_pass++;
    n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b want=1", bus8.in_ready); else n_pass++;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    n_checks++; if (bus8.out_valid !== 1'b1) $display("FAIL bp_next_valid got=%b want=1", bus8.out_valid); else n_pass++;
    n_checks++; if (bus8.out_data !== 8'h11) $display("FAIL bp_next_data got=%h want=11", bus8.out_data); else n_pass++;
    n_checks++; if (bus8.out_count !== 8'd1) $display("FAIL bp_next_count got=%0d want=1", bus8.out_count); else n_pass++;
    pop8();
    $display("test_back_to_back done");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drives(8'h01, 2'd1, (i == 4) ? 1'b1 : 1'b0);
    end
    n_checks++; if (buss.out_valid !== 1'b1) $display("FAIL sat_out_valid got=%b want=1", buss.out_valid); else n_pass++;
    n_checks++; if (buss.out_count !== 2'd3) $display("FAIL sat_out_count got=%0d want=3", buss.out_count); else n_pass++;
    n_checks++; if (buss.out_sat !== 1'b1) $display("FAIL sat_out_sat got=%b want=1", buss.out_sat); else n_pass++;
    n_checks++; if (buss.out_data !== 8'h01) $display("FAIL sat_out_data got=%h want=01", buss.out_data); else n_pass++;
    n_checks++; if (buss.out_bit !== 1'b1) $display("FAIL sat_out_bit got=%b want=1", buss.out_bit); else n_pass++;
    buss.out_ready = 1'b1;
    @(posedge clk); #1;
    buss.out_ready = 1'b0;
    n_checks++; if (buss.out_valid !== 1'b0) $display("FAIL sat_after_pop_valid got=%b want=0", buss.out_valid); else n_pass++;
    $display("test_saturation done");
  endtask

  initial begin
    bus8.in_data = '0; bus8.in_op = '0; bus8.in_last = 1'b0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    buss.in_data = '0; buss.in_op = '0; buss.in_last = 1'b0; buss.in_valid = 1'b0; buss.out_ready = 1'b0;
    test_reset();
    test_reset_mid_packet();
    test_and();
    test_xor_gaps();
    test_nand();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
